// File: rtl/oam_dma_arbiter.sv
// Sprite DMA ($4014) bus arbiter: passes CPU cycles through when idle and
// halts the CPU while 256 bytes of page N are copied to the OAM data port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CPU owns the bus, rdy high, watching for a write to trigger
// HALT  | CPU halted; this cycle still drives the CPU's (dummy) access
// ALIGN | extra read cycle so the first DMA read lands on a get cycle
// READ  | read {page,index}, capture byte into latch
// WRITE | write latch to OAM data port, advance index or finish
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDRESS  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDRESS = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [7:0]  i_cpu_data,
  output logic [7:0]  o_cpu_data,
  output logic        o_cpu_rdy,
  output logic        o_rw,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  input  logic [7:0]  i_data,
  output logic        o_dma_active
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] page;
  logic [7:0] index;
  logic [7:0] latch;
  logic       parity;
  logic       trigger;

  assign trigger = !i_cpu_rw && (i_cpu_address == TRIGGER_ADDRESS);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      page   <= 8'h00;
      index  <= 8'h00;
      latch  <= 8'h00;
      parity <= 1'b0;
    end else begin
      state  <= state_nxt;
      parity <= ~parity;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            page  <= i_cpu_data;
            index <= 8'h00;
          end
        end
        S_READ:  latch <= i_data;
        S_WRITE: begin
          if (index != 8'hFF) index <= index + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    o_rw      = i_cpu_rw;
    o_address = i_cpu_address;
    o_data    = i_cpu_data;
    case (state)
      S_IDLE: begin
        if (trigger) state_nxt = S_HALT;
      end
      // parity high here means the following cycle is a get cycle
      S_HALT: state_nxt = parity ? S_READ : S_ALIGN;
      S_ALIGN: begin
        o_rw      = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        o_rw      = 1'b1;
        o_address = {page, index};
        o_data    = latch;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        o_rw      = 1'b0;
        o_address = OAM_DATA_ADDRESS;
        o_data    = latch;
        state_nxt = (index == 8'hFF) ? S_IDLE : S_READ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_cpu_data   = i_data;
  assign o_cpu_rdy    = (state == S_IDLE);
  assign o_dma_active = (state != S_IDLE);

endmodule
